// File: rtl/calc_pkg.sv
// Shared key codes, ALU opcode encodings and sequencer states for the
// calculator key sequencer and its operand accumulator.
package calc_pkg;

    localparam logic [3:0] KEY_PLUS  = 4'd10;
    localparam logic [3:0] KEY_MINUS = 4'd11;
    localparam logic [3:0] KEY_MUL   = 4'd12;
    localparam logic [3:0] KEY_DIV   = 4'd13;
    localparam logic [3:0] KEY_ENTER = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        A_SIGN,
        A_DIG,
        OPER,
        B_SIGN,
        B_DIG,
        EXEC,
        WAIT,
        SHOW
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_oper(input logic [3:0] k);
        return (k >= KEY_PLUS) && (k <= KEY_DIV);
    endfunction

    // Operator keys are contiguous from '+', so the opcode is the offset.
    function automatic logic [1:0] op_from_key(input logic [3:0] k);
        logic [3:0] d;
        d = k - KEY_PLUS;
        return d[1:0];
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// Key input, arithmetic-unit handshake and display/status bundle of the
// calculator key sequencer.
interface calc_key_sequencer_if #(
    parameter int W = 11
);
    logic                key_valid;
    logic [3:0]          key_code;
    logic signed [W-1:0] op_a;
    logic signed [W-1:0] op_b;
    logic [1:0]          op_sel;
    logic                alu_start;
    logic                alu_done;
    logic signed [W-1:0] alu_result;
    logic                alu_err;
    logic signed [W-1:0] result;
    logic                result_valid;
    logic                busy;
    logic                err;

    modport slave (
        input  key_valid, key_code, alu_done, alu_result, alu_err,
        output op_a, op_b, op_sel, alu_start, result, result_valid, busy, err
    );

    modport master (
        output key_valid, key_code, alu_done, alu_result, alu_err,
        input  op_a, op_b, op_sel, alu_start, result, result_valid, busy, err
    );
endinterface

// File: rtl/calc_operand_acc.sv
// Decimal digit accumulator with digit-count limit and sign; shared between
// operand A and operand B, cleared after each commit.
module calc_operand_acc
    import calc_pkg::*;
#(
    parameter int W          = 11,
    parameter int MAX_DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sign_en,
    input  logic                sign_neg,
    input  logic                digit_en,
    input  logic [3:0]          digit,
    input  logic                clr,
    output logic signed [W-1:0] value
);
    localparam int CW = $clog2(MAX_DIGITS + 1);

    logic [W-1:0]  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          neg_q, neg_d;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        neg_d = neg_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            neg_d = 1'b0;
        end else begin
            if (sign_en) begin
                neg_d = sign_neg;
            end
            // Excess digits are dropped silently; the product wraps at W bits.
            if (digit_en && (cnt_q < CW'(MAX_DIGITS))) begin
                acc_d = acc_q * W'(10) + W'(digit);
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            neg_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            neg_q <= neg_d;
        end
    end

    assign value = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: gathers two signed operands and an operator from
// keypad events, launches the ALU and holds its result. Define
// CALC_SEQ_CHAIN_EN to let an operator key in SHOW chain on the last result.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 11,
    parameter int MAX_DIGITS = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_key_sequencer_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic signed [W-1:0] op_a_q, op_a_d;
    logic signed [W-1:0] op_b_q, op_b_d;
    logic [1:0]          op_sel_q, op_sel_d;
    logic signed [W-1:0] result_q, result_d;
    logic                rv_q, rv_d;
    logic                err_q, err_d;
    logic [TW-1:0]       cnt_q, cnt_d;

    logic                acc_sign_en, acc_sign_neg, acc_digit_en, acc_clr;
    logic signed [W-1:0] acc_value;

    logic [3:0] key;
    logic       busy;
    logic       key_fire;
    logic       chain_op;
    state_t     dig_state;

    assign key       = bus.key_code;
    assign busy      = (state_q == EXEC) || (state_q == WAIT);
    assign key_fire  = bus.key_valid && !busy && (key != KEY_NONE);
    assign dig_state = (state_q == B_SIGN) ? B_DIG : A_DIG;

`ifdef CALC_SEQ_CHAIN_EN
    assign chain_op = (state_q == SHOW) && is_oper(key);
`else
    assign chain_op = 1'b0;
`endif

    calc_operand_acc #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .sign_en  (acc_sign_en),
        .sign_neg (acc_sign_neg),
        .digit_en (acc_digit_en),
        .digit    (key),
        .clr      (acc_clr),
        .value    (acc_value)
    );

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_sel_d     = op_sel_q;
        result_d     = result_q;
        rv_d         = rv_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        acc_sign_en  = 1'b0;
        acc_sign_neg = 1'b0;
        acc_digit_en = 1'b0;
        acc_clr      = 1'b0;

        case (state_q)
            // SHOW treats a key exactly like A_SIGN once the display is dropped.
            A_SIGN, B_SIGN, SHOW: begin
                if (key_fire) begin
                    err_d = 1'b0;
                    rv_d  = 1'b0;
                    if (chain_op) begin
                        op_a_d   = result_q;
                        op_sel_d = op_from_key(key);
                        state_d  = B_SIGN;
                    end else if ((key == KEY_PLUS) || (key == KEY_MINUS)) begin
                        acc_sign_en  = 1'b1;
                        acc_sign_neg = (key == KEY_MINUS);
                        state_d      = dig_state;
                    end else if (is_digit(key)) begin
                        acc_sign_en  = 1'b1;
                        acc_digit_en = 1'b1;
                        state_d      = dig_state;
                    end else if (state_q == SHOW) begin
                        state_d = A_SIGN;
                    end
                end
            end
            A_DIG, B_DIG: begin
                if (key_fire) begin
                    err_d = 1'b0;
                    if (is_digit(key)) begin
                        acc_digit_en = 1'b1;
                    end else if (key == KEY_ENTER) begin
                        acc_clr = 1'b1;
                        if (state_q == A_DIG) begin
                            op_a_d  = acc_value;
                            state_d = OPER;
                        end else begin
                            op_b_d  = acc_value;
                            state_d = EXEC;
                        end
                    end
                end
            end
            OPER: begin
                if (key_fire) begin
                    err_d = 1'b0;
                    if (is_oper(key)) begin
                        op_sel_d = op_from_key(key);
                        state_d  = B_SIGN;
                    end
                end
            end
            EXEC: begin
                // The launch cycle counts as the first cycle of the timeout.
                cnt_d   = TW'(1);
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.alu_done) begin
                    result_d = bus.alu_result;
                    err_d    = bus.alu_err;
                    rv_d     = 1'b1;
                    state_d  = SHOW;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    rv_d     = 1'b0;
                    state_d  = A_SIGN;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            default: state_d = A_SIGN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= A_SIGN;
            op_a_q   <= '0;
            op_b_q   <= '0;
            op_sel_q <= OP_ADD;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            op_sel_q <= op_sel_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.op_a         = op_a_q;
    assign bus.op_b         = op_b_q;
    assign bus.op_sel       = op_sel_q;
    assign bus.alu_start    = (state_q == EXEC);
    assign bus.result       = result_q;
    assign bus.result_valid = rv_q;
    assign bus.busy         = busy;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: directed key sequences push the
// expected ALU launch and result events; a monitor checks them as they appear.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    localparam int W          = 11;
    localparam int MAX_DIGITS = 3;
    localparam int TIMEOUT    = 255;

    typedef struct {
        int a;
        int b;
        int sel;
    } start_exp_t;

    typedef struct {
        int res;
        int rv;
        int er;
        int lat;
    } res_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    calc_key_sequencer_if #(.W(W)) bus ();

    calc_key_sequencer #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_starts = 0;
    int exp_starts = 0;
    int last_start = 0;

    int alu_en = 1;
    int alu_lat = 2;
    int alu_res = 0;
    int alu_errv = 0;

    start_exp_t start_q[$];
    res_exp_t   res_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_start(input int a, input int b, input int sel);
        start_exp_t e;
        e.a = a; e.b = b; e.sel = sel;
        start_q.push_back(e);
        exp_starts++;
    endtask

    task automatic exp_res(input int res, input int rv, input int er, input int lat);
        res_exp_t e;
        e.res = res; e.rv = rv; e.er = er; e.lat = lat;
        res_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] k);
        bus.key_code  = k;
        bus.key_valid = 1'b1;
        @(negedge clk);
        bus.key_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (start_q.size() == 0 && res_q.size() == 0) break;
            @(negedge clk);
        end
        if (start_q.size() != 0 || res_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: pending starts=%0d results=%0d after %0d cycles, expected 0",
                     name, start_q.size(), res_q.size(), bound);
            start_q.delete();
            res_q.delete();
        end
    endtask

    task automatic wait_start(input string name, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (start_q.size() == 0) break;
            @(negedge clk);
        end
        if (start_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no alu_start within %0d cycles", name, bound);
            start_q.delete();
        end
    endtask

    // Arithmetic-unit model: answers each launch after alu_lat cycles.
    initial begin : alu_model
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        bus.alu_err    = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start && alu_en != 0) begin
                repeat (alu_lat) @(negedge clk);
                bus.alu_done   = 1'b1;
                bus.alu_result = W'(alu_res);
                bus.alu_err    = (alu_errv != 0);
                @(negedge clk);
                bus.alu_done   = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic       rv_prev;
        logic       err_prev;
        start_exp_t s;
        res_exp_t   r;
        rv_prev  = 1'b0;
        err_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.alu_start) begin
                n_starts++;
                last_start = cyc;
                if (start_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_start: op_a=%0d op_b=%0d op_sel=%0d, no launch expected",
                             bus.op_a, bus.op_b, bus.op_sel);
                end else begin
                    s = start_q.pop_front();
                    chk("start_op_a", int'(bus.op_a), s.a);
                    chk("start_op_b", int'(bus.op_b), s.b);
                    chk("start_op_sel", int'(bus.op_sel), s.sel);
                    chk("start_busy", int'(bus.busy), 1);
                end
            end
            if ((bus.result_valid && !rv_prev) || (bus.err && !err_prev && !bus.result_valid)) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: result=%0d err=%0d result_valid=%0d, none expected",
                             bus.result, bus.err, bus.result_valid);
                end else begin
                    r = res_q.pop_front();
                    chk("res_value", int'(bus.result), r.res);
                    chk("res_valid", int'(bus.result_valid), r.rv);
                    chk("res_err", int'(bus.err), r.er);
                    chk("res_latency", cyc - last_start, r.lat);
                end
            end
            rv_prev  = bus.result_valid;
            err_prev = bus.err;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;

        #2 rst = 1'b0;
        #2;
        chk("rst_op_a", int'(bus.op_a), 0);
        chk("rst_op_b", int'(bus.op_b), 0);
        chk("rst_op_sel", int'(bus.op_sel), 0);
        chk("rst_result", int'(bus.result), 0);
        chk("rst_result_valid", int'(bus.result_valid), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.err), 0);
        chk("rst_alu_start", int'(bus.alu_start), 0);
        chk("rst_state", int'(dut.state_q), int'(A_SIGN));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // -123 + 45, trailing ENTER lands in EXEC and is dropped
        alu_lat = 2; alu_res = -78; alu_errv = 0;
        exp_start(-123, 45, 0);
        exp_res(-78, 1, 0, 3);
        press(KEY_MINUS); press(4'd1); press(4'd2); press(4'd3); press(KEY_ENTER);
        press(KEY_PLUS); press(4'd4); press(4'd5); press(KEY_ENTER); press(KEY_ENTER);
        wait_idle("t1_idle", 30);
        chk("t1_result_valid", int'(bus.result_valid), 1);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_result_hold", int'(bus.result), -78);

        // 7 / 0 with ALU error; next digit clears status and starts A
        alu_lat = 3; alu_res = 0; alu_errv = 1;
        exp_start(7, 0, 3);
        exp_res(0, 1, 1, 4);
        press(4'd7); press(KEY_ENTER); press(KEY_DIV); press(4'd0); press(KEY_ENTER);
        wait_idle("t2_idle", 30);
        press(4'd5);
        chk("t2_err_cleared", int'(bus.err), 0);
        chk("t2_rv_cleared", int'(bus.result_valid), 0);
        chk("t2_state", int'(dut.state_q), int'(A_DIG));

        // Fourth digit ignored; keys during WAIT dropped
        do_reset();
        alu_lat = 8; alu_res = 500; alu_errv = 0;
        exp_start(999, -2, 2);
        exp_res(500, 1, 0, 9);
        press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(KEY_ENTER);
        press(KEY_MUL); press(KEY_MINUS); press(4'd2); press(KEY_ENTER);
        wait_start("t3_start", 10);
        press(4'd1); press(KEY_PLUS); press(KEY_ENTER); press(4'd7);
        chk("t3_busy", int'(bus.busy), 1);
        chk("t3_op_a_stable", int'(bus.op_a), 999);
        chk("t3_op_b_stable", int'(bus.op_b), -2);
        chk("t3_op_sel_stable", int'(bus.op_sel), 2);
        wait_idle("t3_idle", 30);
        chk("t3_op_a_after", int'(bus.op_a), 999);

        // ALU never answers: timeout error
        do_reset();
        alu_en = 0;
        exp_start(1, 2, 1);
        exp_res(0, 0, 1, TIMEOUT);
        press(4'd1); press(KEY_ENTER); press(KEY_MINUS); press(4'd2); press(KEY_ENTER);
        wait_idle("t4_idle", TIMEOUT + 40);
        chk("t4_busy", int'(bus.busy), 0);
        chk("t4_state", int'(dut.state_q), int'(A_SIGN));
        chk("t4_err_sticky", int'(bus.err), 1);
        press(4'd3);
        chk("t4_err_cleared", int'(bus.err), 0);
        chk("t4_state_after_key", int'(dut.state_q), int'(A_DIG));
        alu_en = 1;

        // Reset during WAIT; late alu_done must be ignored
        do_reset();
        alu_lat = 10; alu_res = 77; alu_errv = 0;
        exp_start(0, 4, 0);
        press(KEY_MINUS); press(KEY_ENTER); press(KEY_PLUS); press(4'd4); press(KEY_ENTER);
        wait_start("t5_start", 10);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_rst_op_b", int'(bus.op_b), 0);
        chk("t5_rst_busy", int'(bus.busy), 0);
        chk("t5_rst_alu_start", int'(bus.alu_start), 0);
        chk("t5_rst_state", int'(dut.state_q), int'(A_SIGN));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("t5_late_rv", int'(bus.result_valid), 0);
        chk("t5_late_err", int'(bus.err), 0);
        chk("t5_late_result", int'(bus.result), 0);
        chk("t5_late_state", int'(dut.state_q), int'(A_SIGN));

        // 4 + 6 = 10, then '*' 3 ENTER
        do_reset();
        alu_lat = 1; alu_res = 10; alu_errv = 0;
        exp_start(4, 6, 0);
        exp_res(10, 1, 0, 2);
        press(4'd4); press(KEY_ENTER); press(KEY_PLUS); press(4'd6); press(KEY_ENTER);
        wait_idle("t6_idle", 30);
`ifdef CALC_SEQ_CHAIN_EN
        alu_res = 30;
        exp_start(10, 3, 2);
        exp_res(30, 1, 0, 2);
        press(KEY_MUL); press(4'd3); press(KEY_ENTER);
        wait_idle("t6_chain_idle", 30);
        chk("t6_chain_op_a", int'(bus.op_a), 10);
`else
        press(KEY_MUL);
        chk("t6_rv_cleared", int'(bus.result_valid), 0);
        chk("t6_state", int'(dut.state_q), int'(A_SIGN));
        press(4'd3); press(KEY_ENTER);
        chk("t6_new_op_a", int'(bus.op_a), 3);
        chk("t6_state_oper", int'(dut.state_q), int'(OPER));
`endif
        repeat (4) @(negedge clk);
        chk("start_count", n_starts, exp_starts);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
- Clocked controller between the keypad scan-code decoder and the calculator arithmetic unit.
- Collects key events into two signed operands and an operator, then launches the arithmetic unit with a start/done handshake.
- Latches the result for the display and reports busy/error status.
- Replaces edge-of-select sequencing with a single-clock FSM.

Parameters:
- W, 11, operand/result width (two's complement).
- MAX_DIGITS, 3, decimal digits accepted per operand.
- TIMEOUT, 255, max cycles waiting for alu_done before error.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- key_valid  in  1  one-cycle strobe; key_code is valid this cycle.
- key_code  in  4  0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 ENTER, 15 ignored.
- op_a  out  W  signed operand A to the arithmetic unit.
- op_b  out  W  signed operand B.
- op_sel  out  2  00 add, 01 sub, 10 mul, 11 div.
- alu_start  out  1  one-cycle launch pulse.
- alu_done  in  1  result valid this cycle.
- alu_result  in  W  arithmetic result.
- alu_err  in  1  qualified by alu_done (e.g. divide by zero).
- result  out  W  latched result for the display.
- result_valid  out  1  high while result is shown.
- busy  out  1  high in EXEC/WAIT; keys are dropped.
- err  out  1  sticky until next accepted key or reset.

Behaviour:
- Reset (async, rst=0): state A_SIGN. op_a, op_b, result, accumulator, digit count = 0. op_sel=00. alu_start, result_valid, busy, err = 0.
- Accumulate: acc <= (acc*10 + digit) truncated to W bits. Digits beyond MAX_DIGITS are ignored; no state change.
- Commit on ENTER: operand <= neg ? -acc : acc (W-bit two's complement). Accumulator and digit count are then cleared.
- A_SIGN:
  - '+' or '-' sets neg_a and goes to A_DIG.
  - A digit sets neg_a=0, is accumulated, and goes to A_DIG.
  - '*', '/' and ENTER are ignored.
- A_DIG:
  - Digit: accumulate.
  - ENTER: commit op_a (zero digits gives 0), go to OPER.
  - Operator keys are ignored.
- OPER: keys 10-13 set op_sel=key_code-10 and go to B_SIGN. Digits and ENTER are ignored.
- B_SIGN / B_DIG: mirror A_SIGN / A_DIG for op_b. ENTER in B_DIG commits op_b and goes to EXEC.
- EXEC: alu_start=1 for exactly one cycle, busy=1, then WAIT. op_a, op_b and op_sel are stable from EXEC until alu_done.
- WAIT:
  - busy=1; a cycle counter runs.
  - alu_done: result<=alu_result, err<=alu_err, result_valid=1, go to SHOW. Latency from alu_start to result_valid is alu latency + 1 cycle.
  - Counter reaches TIMEOUT with no done: err=1, result=0, result_valid=0, go to A_SIGN.
- SHOW: result_valid stays 1.
  - Any accepted key code 0-14 clears result_valid and err, then is processed as an A_SIGN key in the same cycle.
  - key_code 15 is ignored.
- key_valid while busy: dropped, no side effects.
- alu_done outside WAIT: ignored.
- Reset asserted mid-sequence, including during WAIT: immediate return to reset values. A late alu_done after reset is ignored.

Optional Feature:
- Macro: CALC_SEQ_CHAIN_EN.
- Defined: in SHOW, an operator key (10-13) loads op_a<=result, sets op_sel and goes to B_SIGN, enabling chained operations. Other keys behave as without the macro.
- Undefined: operator keys in SHOW are handled as A_SIGN keys. '+' and '-' start a new operand A; '*' and '/' only clear result_valid and err and remain in A_SIGN.

Decomposition:
- Shared package calc_pkg holds:
  - key-code constants (KEY_PLUS=10 … KEY_ENTER=14),
  - op_sel encodings,
  - the FSM state enum (A_SIGN, A_DIG, OPER, B_SIGN, B_DIG, EXEC, WAIT, SHOW).
- One natural sub-module, calc_operand_acc: digit accumulator with count, MAX_DIGITS limit, sign and commit/clear. Instantiated once and reused for A and B.

Test Plan:
- Keys '-',1,2,3,ENTER,'+',4,5,ENTER,ENTER with alu_done 2 cycles after start and alu_result=-78 -> op_a=-123, op_b=45, op_sel=00, one alu_start pulse, result=-78, result_valid=1.
- Keys 7,ENTER,'/',0,ENTER; alu_done with alu_err=1 -> err=1, result_valid=1. Next key 5 -> err=0, result_valid=0, state A_DIG.
- Keys 9,9,9,9,ENTER -> op_a=999 (fourth digit ignored). Keys during WAIT are dropped; op_a, op_b and op_sel are unchanged.
- Operand complete, alu_done never asserted -> err=1 exactly TIMEOUT cycles after alu_start, state A_SIGN, busy=0.
- rst asserted during WAIT, then alu_done -> all outputs at reset values, no result_valid.
- With CALC_SEQ_CHAIN_EN: after result=10, keys '*',3,ENTER -> op_a=10, op_b=3, op_sel=10. Without the macro, the same '*' stays in A_SIGN with result_valid=0.
